shift_cmd_ctrl: RTL and testbench

SHIFT_CMD_CTRL -- requirements
Module: shift_cmd_ctrl

---
 rtl/shift_cmd_ctrl_if.sv | 28 ++
 rtl/shift_cmd_ctrl.sv | 119 +++++++++++
 tb/tb_shift_cmd_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_cmd_ctrl_if.sv
// Command / barrel-shifter / result bundle between shift_cmd_ctrl and its neighbours.
// slave = controller view, master = the side that issues commands, evaluates the shifter and consumes results.
interface shift_cmd_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [2:0] cmd_amt;
    logic       cmd_lr;
    logic       cmd_sweep;
    logic [7:0] sh_a;
    logic [2:0] sh_amt;
    logic       sh_lr;
    logic [7:0] sh_y;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_last;

    modport slave (
        input  cmd_valid, cmd_data, cmd_amt, cmd_lr, cmd_sweep, sh_y, res_ready,
        output cmd_ready, sh_a, sh_amt, sh_lr, res_valid, res_data, res_last
    );

    modport master (
        output cmd_valid, cmd_data, cmd_amt, cmd_lr, cmd_sweep, sh_y, res_ready,
        input  cmd_ready, sh_a, sh_amt, sh_lr, res_valid, res_data, res_last
    );
endinterface

// File: rtl/shift_cmd_ctrl.sv
// Sequences commands through an external combinational barrel shifter, waits for it to settle, returns results.
// Optional amount sweep (cmd_amt..7, one result per step) is compiled in with SHIFT_CMD_CTRL_SWEEP_EN.
module shift_cmd_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    shift_cmd_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, OUT} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] sh_a_q, sh_a_d;
    logic [2:0] sh_amt_q, sh_amt_d;
    logic       sh_lr_q, sh_lr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] res_data_q, res_data_d;
    logic       res_valid_q, res_valid_d;
    logic       last_w;

`ifdef SHIFT_CMD_CTRL_SWEEP_EN
    logic sweep_q, sweep_d;
    assign last_w = !sweep_q || (sh_amt_q == 3'd7);
`else
    logic unused_sweep;
    assign unused_sweep = bus.cmd_sweep;
    assign last_w       = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_a_q      <= '0;
            sh_amt_q    <= '0;
            sh_lr_q     <= 1'b0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_a_q      <= sh_a_d;
            sh_amt_q    <= sh_amt_d;
            sh_lr_q     <= sh_lr_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

`ifdef SHIFT_CMD_CTRL_SWEEP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sweep_q <= 1'b0;
        else       sweep_q <= sweep_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        sh_a_d      = sh_a_q;
        sh_amt_d    = sh_amt_q;
        sh_lr_d     = sh_lr_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
`ifdef SHIFT_CMD_CTRL_SWEEP_EN
        sweep_d     = sweep_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    sh_a_d   = bus.cmd_data;
                    sh_amt_d = bus.cmd_amt;
                    sh_lr_d  = bus.cmd_lr;
`ifdef SHIFT_CMD_CTRL_SWEEP_EN
                    sweep_d  = bus.cmd_sweep;
`endif
                    cnt_d    = SETTLE_LD;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                // Counter runs down through the settle window; sh_y is taken once it has expired,
                // giving SETTLE_CYCLES+1 edges from load to res_valid.
                if (cnt_q == 4'd0) begin
                    res_data_d  = bus.sh_y;
                    res_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            OUT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (last_w) begin
                        state_d = IDLE;
                    end else begin
                        sh_amt_d = sh_amt_q + 3'd1;
                        cnt_d    = SETTLE_LD;
                        state_d  = SETTLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.sh_a      = sh_a_q;
    assign bus.sh_amt    = sh_amt_q;
    assign bus.sh_lr     = sh_lr_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_last  = (state_q == OUT) && last_w;

endmodule

// File: tb/tb_shift_cmd_ctrl.sv
// Directed bench for shift_cmd_ctrl: downstream shifter modelled as an 8-bit rotate, SETTLE_CYCLES = 1.
// Expectations follow SHIFT_CMD_CTRL_SWEEP_EN so the bench works with or without the sweep build.
module tb_shift_cmd_ctrl;

    logic clk;
    logic reset;
    int   nvec;
    int   nerr;

    shift_cmd_ctrl_if bus ();

    shift_cmd_ctrl #(.SETTLE_CYCLES(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rot8(input logic [7:0] a, input logic [2:0] n, input logic right);
        logic [15:0] d;
        logic [15:0] t;
        d = {a, a};
        if (right) begin
            t = d >> n;
            return t[7:0];
        end else begin
            t = d << n;
            return t[15:8];
        end
    endfunction

    assign bus.sh_y = rot8(bus.sh_a, bus.sh_amt, bus.sh_lr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input string tag, input int budget);
        for (int i = 0; i < budget && bus.res_valid !== 1'b1; i++) tick();
        chk(tag, bus.res_valid, 1);
    endtask

    task automatic issue(input logic [7:0] d, input logic [2:0] a, input logic r, input logic s);
        bus.cmd_data  = d;
        bus.cmd_amt   = a;
        bus.cmd_lr    = r;
        bus.cmd_sweep = s;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input logic [7:0] d, input logic [2:0] a,
                             input logic r, input logic s);
        int n_exp;
        logic [2:0] amt;
`ifdef SHIFT_CMD_CTRL_SWEEP_EN
        n_exp = s ? (8 - int'(a)) : 1;
`else
        n_exp = 1;
`endif
        amt = a;
        bus.res_ready = 1'b1;
        issue(d, a, r, s);
        for (int k = 0; k < n_exp; k++) begin
            wait_res({tag, "_valid"}, 8);
            chk({tag, "_data"}, bus.res_data, rot8(d, amt, r));
            chk({tag, "_last"}, bus.res_last, (k == n_exp - 1) ? 1 : 0);
            tick();
            amt = amt + 3'd1;
        end
        chk({tag, "_done_rdy"}, bus.cmd_ready, 1);
        for (int i = 0; i < 6; i++) begin
            chk({tag, "_no_extra"}, bus.res_valid, 0);
            tick();
        end
    endtask

    initial begin
        nvec          = 0;
        nerr          = 0;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_amt   = '0;
        bus.cmd_lr    = 1'b0;
        bus.cmd_sweep = 1'b0;
        bus.res_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_sh_a", bus.sh_a, 0);
        chk("rst_res_last", bus.res_last, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", bus.cmd_ready, 1);

        // Single right shift: 2B rotr 2 = CA, valid two edges after accept
        bus.res_ready = 1'b1;
        issue(8'h2B, 3'd2, 1'b1, 1'b0);
        chk("single_busy", bus.cmd_ready, 0);
        chk("single_sh_a", bus.sh_a, 8'h2B);
        chk("single_sh_amt", bus.sh_amt, 3'd2);
        chk("single_sh_lr", bus.sh_lr, 1);
        chk("single_early", bus.res_valid, 0);
        tick();
        chk("single_early2", bus.res_valid, 0);
        tick();
        chk("single_valid", bus.res_valid, 1);
        chk("single_data", bus.res_data, 8'hCA);
        chk("single_last", bus.res_last, 1);
        tick();
        chk("single_cleared", bus.res_valid, 0);
        chk("single_ready", bus.cmd_ready, 1);

        // Left sweep from 5: 20, 40, 80 (single 20 without sweep build)
        run_sweep("lsweep", 8'h01, 3'd5, 1'b0, 1'b1);

        // Sweep request from 3: five results with sweep build, one otherwise
        run_sweep("sweep3", 8'h01, 3'd3, 1'b0, 1'b1);

        // Backpressure: 96 rotr 3 = D2 held for 10 cycles
        bus.res_ready = 1'b0;
        issue(8'h96, 3'd3, 1'b1, 1'b0);
        wait_res("bp_valid", 8);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", bus.res_valid, 1);
            chk("bp_hold_data", bus.res_data, 8'hD2);
            chk("bp_hold_busy", bus.cmd_ready, 0);
            chk("bp_hold_sh_a", bus.sh_a, 8'h96);
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        chk("bp_done_valid", bus.res_valid, 0);
        chk("bp_done_ready", bus.cmd_ready, 1);

        // Reset in the middle of a sweep from 0 (rotl of 81: 81, 03, ...)
        bus.res_ready = 1'b1;
        issue(8'h81, 3'd0, 1'b0, 1'b1);
        wait_res("mid_r1", 8);
        chk("mid_r1_data", bus.res_data, 8'h81);
`ifdef SHIFT_CMD_CTRL_SWEEP_EN
        tick();
        wait_res("mid_r2", 8);
        chk("mid_r2_data", bus.res_data, 8'h03);
`endif
        bus.res_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", bus.res_valid, 0);
        chk("mid_rst_data", bus.res_data, 0);
        chk("mid_rst_last", bus.res_last, 0);
        chk("mid_rst_sh_a", bus.sh_a, 0);
        chk("mid_rst_sh_amt", bus.sh_amt, 0);
        chk("mid_rst_sh_lr", bus.sh_lr, 0);
        chk("mid_rst_ready", bus.cmd_ready, 1);
        tick();
        reset = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("mid_rst_quiet", bus.res_valid, 0);
            tick();
        end
        issue(8'h2B, 3'd2, 1'b1, 1'b0);
        tick();
        tick();
        chk("mid_new_valid", bus.res_valid, 1);
        chk("mid_new_data", bus.res_data, 8'hCA);
        tick();

        // Back-to-back: valid held across completion, second command waits one edge
        bus.res_ready = 1'b1;
        bus.cmd_data  = 8'h0F;
        bus.cmd_amt   = 3'd4;
        bus.cmd_lr    = 1'b1;
        bus.cmd_sweep = 1'b0;
        bus.cmd_valid = 1'b1;
        tick();
        chk("b2b_a_sh_a", bus.sh_a, 8'h0F);
        chk("b2b_a_busy", bus.cmd_ready, 0);
        bus.cmd_data  = 8'h3C;
        bus.cmd_amt   = 3'd1;
        bus.cmd_lr    = 1'b0;
        tick();
        tick();
        chk("b2b_a_valid", bus.res_valid, 1);
        chk("b2b_a_data", bus.res_data, 8'hF0);
        tick();
        chk("b2b_idle_ready", bus.cmd_ready, 1);
        chk("b2b_not_yet", bus.sh_a, 8'h0F);
        tick();
        bus.cmd_valid = 1'b0;
        chk("b2b_b_sh_a", bus.sh_a, 8'h3C);
        chk("b2b_b_busy", bus.cmd_ready, 0);
        tick();
        tick();
        chk("b2b_b_valid", bus.res_valid, 1);
        chk("b2b_b_data", bus.res_data, 8'h78);
        tick();
        chk("b2b_b_done", bus.cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
